simframe_gen_mm: RTL and testbench

- Multi-mode successor to the fixed-replication simulated-frame generator.
- Accepts a PATTERN_WIDTH seed on an AXI-Stream input and emits frames on a wide AXI-Stream output, each frame being PKTS_PER_FRAME packets of CYCLES_PER_PKT cycles.
- Adds a selectable data mode (constant, lane-ramp, cycle-ramp), repeat of N frames per seed, a start-of-frame TUSER flag, and a running frame counter.
- Sits between the pattern source (DMA/register FIFO) and the frame-stream consumer in the bench-side emulator.

---
 rtl/simframe_gen_mm.sv | 126 ++++++++++++
 tb/tb_simframe_gen_mm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/simframe_gen_mm.sv
// Multi-mode simulated-frame generator: replicates a seed across the output
// lanes as constant, lane-ramp or cycle-ramp data, repeated for N frames per seed.
module simframe_gen_mm #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512,
  parameter int CNT_WIDTH     = 16,
  parameter int FCNT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [CNT_WIDTH-1:0]     CYCLES_PER_PKT,
  input  logic [CNT_WIDTH-1:0]     PKTS_PER_FRAME,
  input  logic [CNT_WIDTH-1:0]     FRAMES_PER_SEED,
  input  logic [1:0]               MODE,
  input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic [OUTPUT_WIDTH-1:0]  AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TVALID,
  output logic                     AXIS_OUT_TLAST,
  output logic                     AXIS_OUT_TUSER,
  input  logic                     AXIS_OUT_TREADY,
  output logic [FCNT_WIDTH-1:0]    FRAME_COUNT,
  output logic                     BUSY
);
  localparam int REPEATS = OUTPUT_WIDTH / PATTERN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [PATTERN_WIDTH-1:0] seed, c_idx;
  logic [1:0]               mode_q;
  logic [CNT_WIDTH-1:0]     cpp_q, ppf_q, fps_q;
  logic [CNT_WIDTH-1:0]     cyc_cnt, pkt_cnt, frm_cnt;
  logic                     sof;
  logic [FCNT_WIDTH-1:0]    fcnt;

  logic out_hs, in_hs, last_cyc, frame_end, all_end;

  function automatic logic [CNT_WIDTH-1:0] eff(input logic [CNT_WIDTH-1:0] x);
    return (x == '0) ? ONE : x;
  endfunction

  assign last_cyc  = (cyc_cnt == cpp_q - ONE);
  assign out_hs    = (state == RUN) && AXIS_OUT_TREADY;
  assign frame_end = out_hs && last_cyc && (pkt_cnt == ppf_q - ONE);
  assign all_end   = frame_end && (frm_cnt == fps_q - ONE);

  // In RUN the next seed is only taken on the very last beat, giving gapless chaining.
  assign AXIS_IN_TREADY = (state == IDLE) ? resetn : all_end;
  assign in_hs          = AXIS_IN_TVALID && AXIS_IN_TREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      seed    <= '0;
      c_idx   <= '0;
      mode_q  <= '0;
      cpp_q   <= '0;
      ppf_q   <= '0;
      fps_q   <= '0;
      cyc_cnt <= '0;
      pkt_cnt <= '0;
      frm_cnt <= '0;
      sof     <= 1'b0;
      fcnt    <= '0;
    end else begin
      if (out_hs) begin
        sof <= 1'b0;
        if (!last_cyc) begin
          cyc_cnt <= cyc_cnt + ONE;
          c_idx   <= c_idx + 1'b1;
        end else begin
          cyc_cnt <= '0;
          if (!frame_end) begin
            pkt_cnt <= pkt_cnt + ONE;
            c_idx   <= c_idx + 1'b1;
          end else begin
            pkt_cnt <= '0;
            c_idx   <= '0;
            sof     <= 1'b1;
            fcnt    <= fcnt + 1'b1;
            frm_cnt <= all_end ? '0 : frm_cnt + ONE;
          end
        end
      end
      // A load overrides the counter advance above.
      if (in_hs) begin
        state   <= RUN;
        seed    <= AXIS_IN_TDATA;
        mode_q  <= MODE;
        cpp_q   <= eff(CYCLES_PER_PKT);
        ppf_q   <= eff(PKTS_PER_FRAME);
        fps_q   <= eff(FRAMES_PER_SEED);
        cyc_cnt <= '0;
        pkt_cnt <= '0;
        frm_cnt <= '0;
        c_idx   <= '0;
        sof     <= 1'b1;
      end else if (all_end) begin
        state <= IDLE;
      end
    end
  end

  logic [REPEATS-1:0][PATTERN_WIDTH-1:0] lanes;

  for (genvar k = 0; k < REPEATS; k++) begin : g_lane
    always_comb begin
      case (mode_q)
        2'd1:    lanes[k] = seed + PATTERN_WIDTH'(k);
        2'd2:    lanes[k] = seed + c_idx;
        default: lanes[k] = seed;
      endcase
    end
  end

  assign AXIS_OUT_TDATA  = lanes;
  assign AXIS_OUT_TVALID = (state == RUN);
  assign AXIS_OUT_TLAST  = (state == RUN) && last_cyc;
  assign AXIS_OUT_TUSER  = (state == RUN) && sof;
  assign FRAME_COUNT     = fcnt;
  assign BUSY            = (state == RUN);

endmodule

// File: tb/tb_simframe_gen_mm.sv
// Bench for simframe_gen_mm: directed and random seeds against a frame-level
// reference model, with optional random downstream backpressure.
module tb_simframe_gen_mm;
  logic         clk = 1'b0;
  logic         resetn;
  logic [15:0]  cpp_in, ppf_in, fps_in;
  logic [1:0]   mode_in;
  logic [31:0]  in_tdata;
  logic         in_tvalid, in_tready;
  logic [511:0] out_tdata;
  logic         out_tvalid, out_tlast, out_tuser, out_tready;
  logic [31:0]  frame_count;
  logic         busy;

  simframe_gen_mm dut (
    .clk(clk), .resetn(resetn),
    .CYCLES_PER_PKT(cpp_in), .PKTS_PER_FRAME(ppf_in), .FRAMES_PER_SEED(fps_in),
    .MODE(mode_in),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(in_tready),
    .AXIS_OUT_TDATA(out_tdata), .AXIS_OUT_TVALID(out_tvalid), .AXIS_OUT_TLAST(out_tlast),
    .AXIS_OUT_TUSER(out_tuser), .AXIS_OUT_TREADY(out_tready),
    .FRAME_COUNT(frame_count), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seed;
    logic [1:0]  mode;
    logic [15:0] cpp, ppf, fps;
  } cfg_t;

  typedef struct {
    logic [511:0] d;
    logic         l, u, ls;
  } beat_t;

  cfg_t  cfgq[$];
  beat_t expq[$];
  int    vectors = 0, miscompares = 0;
  int    exp_fc = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Frame-level model: lists every beat the seed should produce.
  task automatic add_cfg(input logic [31:0] seed, input logic [1:0] mode,
                         input logic [15:0] cpp, input logic [15:0] ppf, input logic [15:0] fps);
    cfg_t  c;
    beat_t b;
    int    ce, pe, fe;
    logic [31:0] v;
    c.seed = seed; c.mode = mode; c.cpp = cpp; c.ppf = ppf; c.fps = fps;
    cfgq.push_back(c);
    ce = (cpp == 0) ? 1 : int'(cpp);
    pe = (ppf == 0) ? 1 : int'(ppf);
    fe = (fps == 0) ? 1 : int'(fps);
    for (int f = 0; f < fe; f++) begin
      for (int ci = 0; ci < ce * pe; ci++) begin
        for (int k = 0; k < 16; k++) begin
          case (mode)
            2'd1:    v = seed + 32'(k);
            2'd2:    v = seed + 32'(ci);
            default: v = seed;
          endcase
          b.d[k*32 +: 32] = v;
        end
        b.l  = ((ci % ce) == ce - 1);
        b.u  = (ci == 0);
        b.ls = (f == fe - 1) && (ci == ce * pe - 1);
        expq.push_back(b);
      end
    end
    exp_fc += fe;
  endtask

  task automatic drive(input int i);
    in_tdata  = cfgq[i].seed;
    mode_in   = cfgq[i].mode;
    cpp_in    = cfgq[i].cpp;
    ppf_in    = cfgq[i].ppf;
    fps_in    = cfgq[i].fps;
    in_tvalid = 1'b1;
  endtask

  // Junk on the config inputs while no seed is offered: must not affect a running frame.
  task automatic drive_junk();
    in_tdata  = $urandom;
    mode_in   = 2'($urandom);
    cpp_in    = 16'($urandom);
    ppf_in    = 16'($urandom);
    fps_in    = 16'($urandom);
    in_tvalid = 1'b0;
  endtask

  task automatic run(input bit bp);
    int sidx = 0, cyc = 0, gaps = 0, nseeds;
    bit started = 0, stalled = 0;
    logic [511:0] pd = '0;
    logic pl = 0, pu = 0;
    beat_t e;
    nseeds = cfgq.size();
    drive(0);
    while ((expq.size() > 0 || sidx < nseeds) && cyc < 4000) begin
      out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        chk("stall_tdata", out_tdata, pd);
        chk("stall_tlast", 512'(out_tlast), 512'(pl));
        chk("stall_tuser", 512'(out_tuser), 512'(pu));
      end
      if (started && !out_tvalid && expq.size() > 0) gaps++;
      stalled = out_tvalid && !out_tready;
      pd = out_tdata; pl = out_tlast; pu = out_tuser;
      if (stalled) chk("in_ready_stall", 512'(in_tready), 512'(0));
      if (in_tvalid && in_tready) begin
        sidx++;
        started = 1;
      end
      if (out_tvalid && out_tready) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 512'(expq.size()), 512'(1));
        end else begin
          e = expq.pop_front();
          chk("tdata", out_tdata, e.d);
          chk("tlast", 512'(out_tlast), 512'(e.l));
          chk("tuser", 512'(out_tuser), 512'(e.u));
          chk("in_ready_beat", 512'(in_tready), 512'(e.ls));
          chk("busy_run", 512'(busy), 512'(1));
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (sidx < nseeds) drive(sidx);
      else drive_junk();
    end
    if (cyc >= 4000) chk("timeout_beats_left", 512'(expq.size()), 512'(0));
    #1;
    chk("frame_count", 512'(frame_count), 512'(32'(exp_fc)));
    chk("idle_tvalid", 512'(out_tvalid), 512'(0));
    chk("idle_busy", 512'(busy), 512'(0));
    chk("idle_in_ready", 512'(in_tready), 512'(1));
    if (!bp) chk("bubbles", 512'(gaps), 512'(0));
    cfgq.delete();
    expq.delete();
  endtask

  initial begin
    resetn     = 1'b0;
    out_tready = 1'b1;
    drive_junk();
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", 512'(out_tvalid), 512'(0));
    chk("rst_in_ready", 512'(in_tready), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_fcount", 512'(frame_count), 512'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready_after_rst", 512'(in_tready), 512'(1));

    // Constant mode, 2 packets of 4 cycles.
    add_cfg(32'hA5A5_0001, 2'd0, 16'd4, 16'd2, 16'd1);
    run(0);
    // Lane ramp across the 32-bit wrap.
    add_cfg(32'hFFFF_FFFE, 2'd1, 16'd2, 16'd1, 16'd1);
    run(0);
    // Cycle ramp, two repeated frames from one seed.
    add_cfg(32'h0000_0010, 2'd2, 16'd3, 16'd2, 16'd2);
    run(0);
    // Back-to-back seeds with no idle cycle between them.
    add_cfg(32'h0000_0001, 2'd2, 16'd2, 16'd2, 16'd1);
    add_cfg(32'h0000_0002, 2'd0, 16'd1, 16'd1, 16'd1);
    add_cfg(32'h0000_0003, 2'd1, 16'd3, 16'd1, 16'd2);
    run(0);
    // Degenerate configs with backpressure.
    add_cfg(32'h1234_5678, 2'd1, 16'd0, 16'd0, 16'd0);
    run(1);
    add_cfg(32'hDEAD_BEEF, 2'd3, 16'd1, 16'd3, 16'd1);
    run(1);
    // Random configs and seeds under 50% backpressure.
    for (int it = 0; it < 8; it++) begin
      add_cfg($urandom, 2'($urandom), 16'($urandom_range(0, 4)),
              16'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
      if (it % 2 == 1)
        add_cfg($urandom, 2'($urandom), 16'($urandom_range(0, 4)),
                16'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
      run(1);
    end

    // Reset in the middle of a packet.
    add_cfg(32'h0BAD_F00D, 2'd0, 16'd8, 16'd1, 16'd1);
    drive(0);
    out_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_junk();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("mid_tvalid", 512'(out_tvalid), 512'(1));
    resetn = 1'b0;
    #1;
    chk("arst_tvalid", 512'(out_tvalid), 512'(0));
    chk("arst_fcount", 512'(frame_count), 512'(0));
    chk("arst_busy", 512'(busy), 512'(0));
    chk("arst_in_ready", 512'(in_tready), 512'(0));
    cfgq.delete();
    expq.delete();
    exp_fc = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 512'(in_tready), 512'(1));
    chk("post_rst_tvalid", 512'(out_tvalid), 512'(0));

    // Normal operation resumes after the reset.
    add_cfg(32'h0000_00AA, 2'd2, 16'd2, 16'd1, 16'd1);
    run(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
